// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

  localparam int PC_W   = 32;
  localparam int WORD_W = 16;

  // Decode treats this word as a no-op; used to flush IF/ID.
  localparam logic [WORD_W-1:0] NOP_WORD = 16'h4000;

  // LDM major opcode (top five bits of the instruction word), shared with decode.
  localparam logic [4:0] OPC_LDM = 5'b10001;

  typedef enum logic [2:0] {
    BOOT_HI,
    BOOT_LO,
    RUN,
    IRQ_HOLD,
    IRQ_HI,
    IRQ_LO
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - bundle of imem, pipeline-control and IF/ID signals around fetch
interface fetch_unit_if;
  import fetch_pkg::*;

  logic [PC_W-1:0]   imem_addr;
  logic [WORD_W-1:0] imem_rdata;
  logic              stall;
  logic              clear_instruction;
  logic              jump_taken;
  logic [PC_W-1:0]   jump_target;
  logic              pc_choose_memory;
  logic [PC_W-1:0]   mem_pc;
  logic              int_req;
  logic              irq_vector_load;
  logic [WORD_W-1:0] instruction;
  logic [PC_W-1:0]   pc_out;
  logic [WORD_W-1:0] imm_out;
  logic              interrupt_signal;

  // The fetch unit side.
  modport master (
    output imem_addr, instruction, pc_out, imm_out, interrupt_signal,
    input  imem_rdata, stall, clear_instruction, jump_taken, jump_target,
           pc_choose_memory, mem_pc, int_req, irq_vector_load
  );

  // Memory, decode, execute and interrupt-source side.
  modport slave (
    input  imem_addr, instruction, pc_out, imm_out, interrupt_signal,
    output imem_rdata, stall, clear_instruction, jump_taken, jump_target,
           pc_choose_memory, mem_pc, int_req, irq_vector_load
  );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// rtl/fetch_unit_if_id_reg.sv - IF/ID pipeline register with load, flush-to-NOP and hold
module if_id_reg
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              load_instr_i,
  input  logic              load_pc_i,
  input  logic              load_imm_i,
  input  logic [WORD_W-1:0] instr_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [WORD_W-1:0] imm_i,
  output logic [WORD_W-1:0] instruction_o,
  output logic [PC_W-1:0]   pc_out_o,
  output logic [WORD_W-1:0] imm_out_o
);

  logic [WORD_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [WORD_W-1:0] imm_q, imm_d;

  // Each field holds unless its own load is asserted; flush overrides the instruction only.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    if (flush_i) begin
      instr_d = NOP_WORD;
    end else if (load_instr_i) begin
      instr_d = instr_i;
    end
    if (load_pc_i) begin
      pc_d = pc_i;
    end
    if (load_imm_i) begin
      imm_d = imm_i;
    end
  end

  // Register update with synchronous active-low reset to an empty (NOP) slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q <= NOP_WORD;
      pc_q    <= '0;
      imm_q   <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
    end
  end

  assign instruction_o = instr_q;
  assign pc_out_o      = pc_q;
  assign imm_out_o     = imm_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC, boot/IRQ vectors, redirects, IF/ID load
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VEC_ADDR = 32'd0,
  parameter logic [PC_W-1:0] IRQ_VEC_ADDR   = 32'd2
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  fetch_state_t      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              irq_pending_q, irq_pending_d;

  logic [PC_W-1:0]   pc_inc;
  logic              run_free;
  logic              accept;
  logic [PC_W-1:0]   imem_addr;
  logic              flush;
  logic              load_instr;
  logic              load_pc;
  logic              load_imm;
  logic [PC_W-1:0]   if_pc;

  assign pc_inc = pc_q + 32'd1;

  // A RUN cycle not consumed by a redirect or stall; an interrupt is taken only if LDM is not pending.
  assign run_free = (state_q == RUN) && !bus.pc_choose_memory && !bus.jump_taken && !bus.stall;
  assign accept   = run_free && !bus.clear_instruction && irq_pending_q;

  // State, PC and interrupt latch registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= BOOT_HI;
      pc_q          <= '0;
      irq_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      irq_pending_q <= irq_pending_d;
    end
  end

  // Next state: two-word vector loads around RUN, with a hold while decode pushes context.
  always_comb begin
    state_d       = state_q;
    irq_pending_d = bus.int_req || (irq_pending_q && !accept);
    case (state_q)
      BOOT_HI:  state_d = BOOT_LO;
      BOOT_LO:  state_d = RUN;
      RUN:      if (accept) state_d = IRQ_HOLD;
      IRQ_HOLD: if (bus.irq_vector_load) state_d = IRQ_HI;
      IRQ_HI:   state_d = IRQ_LO;
      IRQ_LO:   state_d = RUN;
      default:  state_d = BOOT_HI;
    endcase
  end

  // Outputs: imem address, next PC and IF/ID controls following the RUN priority order.
  always_comb begin
    imem_addr  = pc_q;
    pc_d       = pc_q;
    flush      = 1'b0;
    load_instr = 1'b0;
    load_pc    = 1'b0;
    load_imm   = 1'b0;
    if_pc      = pc_inc;
    case (state_q)
      BOOT_HI: begin
        imem_addr = RESET_VEC_ADDR;
        pc_d      = {bus.imem_rdata, pc_q[15:0]};
        flush     = 1'b1;
      end
      BOOT_LO: begin
        imem_addr = RESET_VEC_ADDR + 32'd1;
        pc_d      = {pc_q[31:16], bus.imem_rdata};
        flush     = 1'b1;
      end
      IRQ_HI: begin
        imem_addr = IRQ_VEC_ADDR;
        pc_d      = {bus.imem_rdata, pc_q[15:0]};
        flush     = 1'b1;
      end
      IRQ_LO: begin
        imem_addr = IRQ_VEC_ADDR + 32'd1;
        pc_d      = {pc_q[31:16], bus.imem_rdata};
        flush     = 1'b1;
      end
      IRQ_HOLD: begin
        // PC stays at the next unexecuted word; pc_out already holds it for decode.
        flush = 1'b1;
      end
      RUN: begin
        if (bus.pc_choose_memory) begin
          pc_d  = bus.mem_pc;
          flush = 1'b1;
        end else if (bus.jump_taken) begin
          pc_d  = bus.jump_target;
          flush = 1'b1;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.clear_instruction) begin
          // Current word is the LDM immediate, not an instruction.
          pc_d     = pc_inc;
          flush    = 1'b1;
          load_imm = 1'b1;
        end else if (irq_pending_q) begin
          flush   = 1'b1;
          load_pc = 1'b1;
          if_pc   = pc_q;
        end else begin
          pc_d       = pc_inc;
          load_instr = 1'b1;
          load_pc    = 1'b1;
        end
      end
      default: begin
        flush = 1'b1;
      end
    endcase
  end

  assign bus.imem_addr        = imem_addr;
  assign bus.interrupt_signal = accept;

  if_id_reg u_if_id (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush),
    .load_instr_i (load_instr),
    .load_pc_i    (load_pc),
    .load_imm_i   (load_imm),
    .instr_i      (bus.imem_rdata),
    .pc_i         (if_pc),
    .imm_i        (bus.imem_rdata),
    .instruction_o(bus.instruction),
    .pc_out_o     (bus.pc_out),
    .imm_out_o    (bus.imm_out)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a behavioural reference model
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RV = 32'd0;
  localparam logic [31:0] IV = 32'd2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_VEC_ADDR(RV), .IRQ_VEC_ADDR(IV)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [15:0] imem [0:4095];
  assign bus.imem_rdata = imem[bus.imem_addr[11:0]];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a PC, a count of vector words still to fetch, a "waiting for decode" flag.
  int          m_words_left;
  logic [31:0] m_vec_base;
  bit          m_waiting;
  bit          m_pending;
  logic [31:0] m_pc;
  logic [15:0] m_instr;
  logic [31:0] m_pc_out;
  logic [15:0] m_imm;

  function automatic logic [31:0] exp_addr();
    if (m_words_left > 0) return m_vec_base + 32'(2 - m_words_left);
    return m_pc;
  endfunction

  function automatic bit exp_accept();
    return (m_words_left == 0) && !m_waiting && m_pending && !bus.pc_choose_memory &&
           !bus.jump_taken && !bus.stall && !bus.clear_instruction;
  endfunction

  task automatic model_edge();
    logic [31:0] a;
    logic [15:0] rd;
    bit acc;
    a   = exp_addr();
    rd  = imem[a[11:0]];
    acc = exp_accept();
    if (!reset) begin
      m_words_left = 2; m_vec_base = RV; m_waiting = 0; m_pending = 0;
      m_pc = 0; m_instr = NOP_WORD; m_pc_out = 0; m_imm = 0;
      return;
    end
    if (m_words_left > 0) begin
      if (m_words_left == 2) m_pc[31:16] = rd;
      else m_pc[15:0] = rd;
      m_words_left--;
      m_instr = NOP_WORD;
    end else if (m_waiting) begin
      if (bus.irq_vector_load) begin
        m_waiting = 0; m_words_left = 2; m_vec_base = IV;
      end
    end else if (bus.pc_choose_memory) begin
      m_pc = bus.mem_pc; m_instr = NOP_WORD;
    end else if (bus.jump_taken) begin
      m_pc = bus.jump_target; m_instr = NOP_WORD;
    end else if (bus.stall) begin
      m_pc = m_pc;
    end else if (bus.clear_instruction) begin
      m_imm = rd; m_instr = NOP_WORD; m_pc = m_pc + 1;
    end else if (m_pending) begin
      m_instr = NOP_WORD; m_pc_out = m_pc; m_waiting = 1;
    end else begin
      m_instr = rd; m_pc = m_pc + 1; m_pc_out = m_pc;
    end
    m_pending = bus.int_req || (m_pending && !acc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.clear_instruction = 0; bus.jump_taken = 0; bus.jump_target = 0;
    bus.pc_choose_memory = 0; bus.mem_pc = 0; bus.int_req = 0; bus.irq_vector_load = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    tick();
    tick();
    vectors++;
    if (bus.instruction !== NOP_WORD) begin
      miscompares++; $display("FAIL reset_instr: got %h want %h", bus.instruction, NOP_WORD);
    end
    vectors++;
    if (bus.pc_out !== 32'h0) begin
      miscompares++; $display("FAIL reset_pc_out: got %h want 0", bus.pc_out);
    end
    vectors++;
    if (bus.imm_out !== 16'h0) begin
      miscompares++; $display("FAIL reset_imm: got %h want 0", bus.imm_out);
    end
    vectors++;
    if (bus.interrupt_signal !== 1'b0) begin
      miscompares++; $display("FAIL reset_irq: got %b want 0", bus.interrupt_signal);
    end
    vectors++;
    if (bus.imem_addr !== RV) begin
      miscompares++; $display("FAIL reset_addr: got %h want %h", bus.imem_addr, RV);
    end
  endtask

  task automatic test_boot();
    reset = 1;
    tick();
    vectors++;
    if (bus.imem_addr !== 32'h1) begin
      miscompares++; $display("FAIL boot_addr_lo: got %h want 1", bus.imem_addr);
    end
    tick();
    vectors++;
    if (bus.imem_addr !== 32'h10) begin
      miscompares++; $display("FAIL boot_addr_run: got %h want 10", bus.imem_addr);
    end
    vectors++;
    if (bus.instruction !== NOP_WORD) begin
      miscompares++; $display("FAIL boot_instr: got %h want %h", bus.instruction, NOP_WORD);
    end
  endtask

  task automatic test_ldm();
    tick();
    vectors++;
    if (bus.instruction !== {OPC_LDM, 11'h005} || bus.pc_out !== 32'h11) begin
      miscompares++;
      $display("FAIL ldm_fetch: got instr %h pc_out %h want %h 11", bus.instruction, bus.pc_out, {OPC_LDM, 11'h005});
    end
    bus.clear_instruction = 1;
    tick();
    bus.clear_instruction = 0;
    vectors++;
    if (bus.imm_out !== 16'hBEEF || bus.instruction !== NOP_WORD || bus.imem_addr !== 32'h12) begin
      miscompares++;
      $display("FAIL ldm_imm: got imm %h instr %h addr %h want beef 4000 12", bus.imm_out, bus.instruction, bus.imem_addr);
    end
  endtask

  task automatic test_redirect_priority();
    bus.jump_taken = 1; bus.jump_target = 32'h40;
    bus.pc_choose_memory = 1; bus.mem_pc = 32'h80;
    tick();
    bus.pc_choose_memory = 0;
    vectors++;
    if (bus.imem_addr !== 32'h80 || bus.instruction !== NOP_WORD) begin
      miscompares++; $display("FAIL redir_mem_wins: got addr %h instr %h want 80 4000", bus.imem_addr, bus.instruction);
    end
    bus.stall = 1;
    tick();
    bus.stall = 0; bus.jump_taken = 0;
    vectors++;
    if (bus.imem_addr !== 32'h40 || bus.instruction !== NOP_WORD) begin
      miscompares++; $display("FAIL redir_jump_over_stall: got addr %h instr %h want 40 4000", bus.imem_addr, bus.instruction);
    end
  endtask

  task automatic finish_isr_entry();
    bus.irq_vector_load = 1;
    tick();
    bus.irq_vector_load = 0;
    tick();
    tick();
  endtask

  task automatic test_interrupt();
    bus.jump_taken = 1; bus.jump_target = 32'h1F;
    tick();
    bus.jump_taken = 0;
    bus.int_req = 1;
    tick();
    bus.int_req = 0;
    #1;
    vectors++;
    if (bus.interrupt_signal !== 1'b1 || bus.imem_addr !== 32'h20) begin
      miscompares++; $display("FAIL irq_accept: got sig %b addr %h want 1 20", bus.interrupt_signal, bus.imem_addr);
    end
    tick();
    vectors++;
    if (bus.interrupt_signal !== 1'b0 || bus.pc_out !== 32'h20 || bus.instruction !== NOP_WORD) begin
      miscompares++;
      $display("FAIL irq_hold: got sig %b pc_out %h instr %h want 0 20 4000", bus.interrupt_signal, bus.pc_out, bus.instruction);
    end
    bus.jump_taken = 1; bus.jump_target = 32'h55; bus.pc_choose_memory = 1; bus.mem_pc = 32'h66;
    tick();
    tick();
    bus.jump_taken = 0; bus.pc_choose_memory = 0;
    vectors++;
    if (bus.imem_addr !== 32'h20 || bus.pc_out !== 32'h20) begin
      miscompares++; $display("FAIL irq_hold_frozen: got addr %h pc_out %h want 20 20", bus.imem_addr, bus.pc_out);
    end
    bus.irq_vector_load = 1;
    tick();
    bus.irq_vector_load = 0;
    vectors++;
    if (bus.imem_addr !== IV) begin
      miscompares++; $display("FAIL irq_vec_hi: got %h want %h", bus.imem_addr, IV);
    end
    tick();
    vectors++;
    if (bus.imem_addr !== IV + 32'd1) begin
      miscompares++; $display("FAIL irq_vec_lo: got %h want %h", bus.imem_addr, IV + 32'd1);
    end
    tick();
    vectors++;
    if (bus.imem_addr !== 32'h100 || bus.instruction !== NOP_WORD) begin
      miscompares++; $display("FAIL irq_resume: got addr %h instr %h want 100 4000", bus.imem_addr, bus.instruction);
    end
    tick();
    vectors++;
    if (bus.instruction !== imem[12'h100] || bus.pc_out !== 32'h101) begin
      miscompares++; $display("FAIL isr_first: got instr %h pc_out %h want %h 101", bus.instruction, bus.pc_out, imem[12'h100]);
    end
  endtask

  task automatic test_irq_vs_ldm_stall();
    bus.int_req = 1;
    tick();
    bus.int_req = 0;
    bus.clear_instruction = 1;
    #1;
    vectors++;
    if (bus.interrupt_signal !== 1'b0) begin
      miscompares++; $display("FAIL irq_blocked_ldm: got %b want 0", bus.interrupt_signal);
    end
    tick();
    bus.clear_instruction = 0;
    bus.stall = 1;
    #1;
    vectors++;
    if (bus.interrupt_signal !== 1'b0) begin
      miscompares++; $display("FAIL irq_blocked_stall: got %b want 0", bus.interrupt_signal);
    end
    tick();
    bus.stall = 0;
    #1;
    vectors++;
    if (bus.interrupt_signal !== 1'b1 || bus.imem_addr !== 32'h103) begin
      miscompares++; $display("FAIL irq_late_accept: got sig %b addr %h want 1 103", bus.interrupt_signal, bus.imem_addr);
    end
    tick();
    vectors++;
    if (bus.pc_out !== 32'h103) begin
      miscompares++; $display("FAIL irq_late_pc_out: got %h want 103", bus.pc_out);
    end
    finish_isr_entry();
  endtask

  task automatic test_reset_mid_irq();
    bus.int_req = 1;
    tick();
    bus.int_req = 0;
    tick();
    bus.irq_vector_load = 1;
    tick();
    bus.irq_vector_load = 0;
    vectors++;
    if (bus.imem_addr !== IV) begin
      miscompares++; $display("FAIL midirq_reach: got %h want %h", bus.imem_addr, IV);
    end
    reset = 0; bus.int_req = 1;
    tick();
    reset = 1; bus.int_req = 0;
    #1;
    vectors++;
    if (bus.imem_addr !== RV || bus.instruction !== NOP_WORD || bus.pc_out !== 32'h0 ||
        bus.imm_out !== 16'h0 || bus.interrupt_signal !== 1'b0) begin
      miscompares++;
      $display("FAIL midirq_reset: got addr %h instr %h pc_out %h imm %h sig %b", bus.imem_addr, bus.instruction,
               bus.pc_out, bus.imm_out, bus.interrupt_signal);
    end
    tick();
    tick();
    vectors++;
    if (bus.imem_addr !== 32'h10 || bus.interrupt_signal !== 1'b0) begin
      miscompares++; $display("FAIL midirq_reboot: got addr %h sig %b want 10 0", bus.imem_addr, bus.interrupt_signal);
    end
    tick();
    vectors++;
    if (bus.imem_addr !== 32'h11 || bus.interrupt_signal !== 1'b0) begin
      miscompares++; $display("FAIL midirq_no_pending: got addr %h sig %b want 11 0", bus.imem_addr, bus.interrupt_signal);
    end
  endtask

  task automatic test_wrap();
    bus.jump_taken = 1; bus.jump_target = 32'hFFFF_FFFF;
    tick();
    bus.jump_taken = 0;
    tick();
    vectors++;
    if (bus.pc_out !== 32'h0 || bus.imem_addr !== 32'h0 || bus.instruction !== imem[12'hFFF]) begin
      miscompares++;
      $display("FAIL pc_wrap: got pc_out %h addr %h instr %h want 0 0 %h", bus.pc_out, bus.imem_addr, bus.instruction, imem[12'hFFF]);
    end
  endtask

  function automatic logic [31:0] rand_target();
    if ($urandom_range(0, 49) == 0) return 32'hFFFF_FFFF;
    return 32'($urandom_range(16'h10, 16'h7FF));
  endfunction

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset                 = ($urandom_range(0, 99) != 0);
      bus.stall             = ($urandom_range(0, 4) == 0);
      bus.clear_instruction = ($urandom_range(0, 9) == 0);
      bus.jump_taken        = ($urandom_range(0, 9) == 0);
      bus.jump_target       = rand_target();
      bus.pc_choose_memory  = ($urandom_range(0, 19) == 0);
      bus.mem_pc            = rand_target();
      bus.int_req           = ($urandom_range(0, 24) == 0);
      bus.irq_vector_load   = ($urandom_range(0, 3) == 0);
      #1;
      vectors++;
      if (bus.imem_addr !== exp_addr() || bus.interrupt_signal !== exp_accept() ||
          bus.instruction !== m_instr || bus.pc_out !== m_pc_out || bus.imm_out !== m_imm) begin
        miscompares++;
        $display("FAIL random[%0d]: got addr %h sig %b instr %h pc_out %h imm %h want %h %b %h %h %h", i,
                 bus.imem_addr, bus.interrupt_signal, bus.instruction, bus.pc_out, bus.imm_out,
                 exp_addr(), exp_accept(), m_instr, m_pc_out, m_imm);
      end
      tick();
    end
    reset = 1;
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) imem[i] = 16'($urandom);
    imem[0]     = 16'h0000;
    imem[1]     = 16'h0010;
    imem[2]     = 16'h0000;
    imem[3]     = 16'h0100;
    imem[12'h10] = {OPC_LDM, 11'h005};
    imem[12'h11] = 16'hBEEF;
    test_reset();
    test_boot();
    test_ldm();
    test_redirect_priority();
    test_interrupt();
    test_irq_vs_ldm_stall();
    test_reset_mid_irq();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
